// File: rtl/eth_phy_10g_tx_pcs_if.sv
// XGMII TX / SERDES TX bundle for the 10GBASE-R transmit PCS.
// master: the MAC side (drives XGMII, observes the SERDES output).
// slave:  the PCS side (consumes XGMII, drives the SERDES output).
interface eth_phy_10g_tx_pcs_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] xgmii_txd;
  logic [CTRL_WIDTH-1:0] xgmii_txc;
  logic [DATA_WIDTH-1:0] serdes_tx_data;
  logic [HDR_WIDTH-1:0]  serdes_tx_hdr;
  logic                  tx_bad_block;

  modport master (
    output xgmii_txd,
    output xgmii_txc,
    input  serdes_tx_data,
    input  serdes_tx_hdr,
    input  tx_bad_block
  );

  modport slave (
    input  xgmii_txd,
    input  xgmii_txc,
    output serdes_tx_data,
    output serdes_tx_hdr,
    output tx_bad_block
  );
endinterface

// File: rtl/eth_phy_10g_tx_pcs.sv
// 10GBASE-R transmit PCS: XGMII -> 64b/66b encoder -> x^58+x^39+1 scrambler -> SERDES.
// Optional PRBS31 test-pattern generator enabled by defining ETH_PHY_10G_TX_PRBS31_EN.
// Latency: encoder register + output register + SERDES_PIPELINE extra stages.
module eth_phy_10g_tx_pcs #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned HDR_WIDTH         = 2,
  parameter int unsigned BIT_REVERSE       = 0,
  parameter int unsigned SCRAMBLER_DISABLE = 0,
  parameter int unsigned SERDES_PIPELINE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_tx_prbs31_enable,
  eth_phy_10g_tx_pcs_if.slave  bus
);

  if (DATA_WIDTH != 64) begin : g_chk_data_width
    $fatal(1, "eth_phy_10g_tx_pcs: DATA_WIDTH must be 64");
  end
  if (CTRL_WIDTH != DATA_WIDTH / 8) begin : g_chk_ctrl_width
    $fatal(1, "eth_phy_10g_tx_pcs: CTRL_WIDTH must be DATA_WIDTH/8");
  end
  if (HDR_WIDTH != 2) begin : g_chk_hdr_width
    $fatal(1, "eth_phy_10g_tx_pcs: HDR_WIDTH must be 2");
  end

  localparam logic [1:0]  SyncData = 2'b10;
  localparam logic [1:0]  SyncCtrl = 2'b01;
  localparam logic [63:0] ErrBlock = {{8{7'h1E}}, 8'h1E};

  function automatic logic [7:0] term_type(input int n);
    case (n)
      0:       term_type = 8'h87;
      1:       term_type = 8'h99;
      2:       term_type = 8'hAA;
      3:       term_type = 8'hB4;
      4:       term_type = 8'hCC;
      5:       term_type = 8'hD2;
      6:       term_type = 8'hE1;
      default: term_type = 8'hFF;
    endcase
  endfunction

  logic [63:0] txd;
  logic [7:0]  txc;

  assign txd = bus.xgmii_txd;
  assign txc = bus.xgmii_txc;

  // Per-lane classification of the XGMII character.
  logic [7:0]      lane_data;
  logic [7:0]      lane_ctrl;
  logic [7:0]      lane_start;
  logic [7:0]      lane_term;
  logic [7:0]      lane_ocode;
  logic [7:0][6:0] ctrl_code;
  logic [7:0][3:0] o_code;

  // Decode each lane into data / control code / start / terminate / O-code.
  always_comb begin
    lane_data  = ~txc;
    lane_ctrl  = '0;
    lane_start = '0;
    lane_term  = '0;
    lane_ocode = '0;
    ctrl_code  = '0;
    o_code     = '0;
    for (int k = 0; k < 8; k++) begin
      if (txc[k]) begin
        case (txd[8*k +: 8])
          8'h07: begin lane_ctrl[k] = 1'b1; ctrl_code[k] = 7'h00; end
          8'h06: begin lane_ctrl[k] = 1'b1; ctrl_code[k] = 7'h06; end
          8'hFE: begin lane_ctrl[k] = 1'b1; ctrl_code[k] = 7'h1E; end
          8'hFB: lane_start[k] = 1'b1;
          8'hFD: lane_term[k] = 1'b1;
          8'h9C: begin lane_ocode[k] = 1'b1; o_code[k] = 4'h0; end
          8'h5C: begin lane_ocode[k] = 1'b1; o_code[k] = 4'hF; end
          default: ;
        endcase
      end
    end
  end

  logic [1:0]  enc_hdr_d, enc_hdr_q;
  logic [63:0] enc_data_d, enc_data_q;
  logic        enc_bad_d, enc_bad_q;
  logic        term_hit;
  logic [7:0]  mask_below;
  logic [7:0]  mask_above;

  // Build the 66-bit block; anything that matches no block type becomes the error block.
  always_comb begin
    enc_hdr_d  = SyncCtrl;
    enc_data_d = ErrBlock;
    enc_bad_d  = 1'b1;
    term_hit   = 1'b0;
    mask_below = '0;
    mask_above = '0;
    if (lane_data == 8'hFF) begin
      enc_hdr_d  = SyncData;
      enc_data_d = txd;
      enc_bad_d  = 1'b0;
    end else if (lane_ctrl == 8'hFF) begin
      enc_data_d[7:0] = 8'h1E;
      for (int k = 0; k < 8; k++) begin
        enc_data_d[8 + 7*k +: 7] = ctrl_code[k];
      end
      enc_bad_d = 1'b0;
    end else if (lane_ctrl[3:0] == 4'hF && lane_ocode[4] && lane_data[7:5] == 3'b111) begin
      enc_data_d = {txd[63:40], o_code[4], ctrl_code[3], ctrl_code[2], ctrl_code[1],
                    ctrl_code[0], 8'h2D};
      enc_bad_d  = 1'b0;
    end else if (lane_ctrl[3:0] == 4'hF && lane_start[4] && lane_data[7:5] == 3'b111) begin
      enc_data_d = {txd[63:40], 4'h0, ctrl_code[3], ctrl_code[2], ctrl_code[1],
                    ctrl_code[0], 8'h33};
      enc_bad_d  = 1'b0;
    end else if (lane_ocode[0] && lane_data[3:1] == 3'b111 && lane_start[4] &&
                 lane_data[7:5] == 3'b111) begin
      enc_data_d = {txd[63:40], 4'h0, o_code[0], txd[31:8], 8'h66};
      enc_bad_d  = 1'b0;
    end else if (lane_ocode[0] && lane_data[3:1] == 3'b111 && lane_ocode[4] &&
                 lane_data[7:5] == 3'b111) begin
      enc_data_d = {txd[63:40], o_code[4], o_code[0], txd[31:8], 8'h55};
      enc_bad_d  = 1'b0;
    end else if (lane_start[0] && lane_data[7:1] == 7'h7F) begin
      enc_data_d = {txd[63:8], 8'h78};
      enc_bad_d  = 1'b0;
    end else if (lane_ocode[0] && lane_data[3:1] == 3'b111 && lane_ctrl[7:4] == 4'hF) begin
      enc_data_d = {ctrl_code[7], ctrl_code[6], ctrl_code[5], ctrl_code[4], o_code[0],
                    txd[31:8], 8'h4B};
      enc_bad_d  = 1'b0;
    end else begin
      // Terminate: data below T, valid control codes above T (codes sit at their 0x1E slots).
      for (int n = 0; n < 8; n++) begin
        mask_below = (8'd1 << n) - 8'd1;
        mask_above = ~((8'd2 << n) - 8'd1);
        if (!term_hit && lane_term[n] && ((lane_data & mask_below) == mask_below) &&
            ((lane_ctrl & mask_above) == mask_above)) begin
          term_hit        = 1'b1;
          enc_data_d      = '0;
          enc_data_d[7:0] = term_type(n);
          for (int i = 0; i < 7; i++) begin
            if (i < n) enc_data_d[8 + 8*i +: 8] = txd[8*i +: 8];
          end
          for (int i = 1; i < 8; i++) begin
            if (i > n) enc_data_d[8 + 7*i +: 7] = ctrl_code[i];
          end
          enc_bad_d = 1'b0;
        end
      end
    end
  end

  // Encoder register; reset leaves the error block in place without flagging it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_hdr_q  <= SyncCtrl;
      enc_data_q <= ErrBlock;
      enc_bad_q  <= 1'b0;
    end else begin
      enc_hdr_q  <= enc_hdr_d;
      enc_data_q <= enc_data_d;
      enc_bad_q  <= enc_bad_d;
    end
  end

  assign bus.tx_bad_block = enc_bad_q;

  logic [57:0] scr_state_d, scr_state_q;
  logic [63:0] scr_data;

  // Self-synchronous scrambler, one bit at a time LSB first; output bit feeds the state.
  always_comb begin
    logic [57:0] s;
    s = scr_state_q;
    scr_data = '0;
    for (int i = 0; i < 64; i++) begin
      scr_data[i] = enc_data_q[i] ^ s[38] ^ s[57];
      s = {s[56:0], scr_data[i]};
    end
    scr_state_d = s;
  end

  // Scrambler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr_state_q <= '1;
    end else begin
      scr_state_q <= scr_state_d;
    end
  end

`ifdef ETH_PHY_10G_TX_PRBS31_EN
  logic [30:0] prbs_d, prbs_q;
  logic [65:0] prbs_bits;

  // PRBS31 generator, 66 bits per clock.
  always_comb begin
    logic [30:0] p;
    p = prbs_q;
    prbs_bits = '0;
    for (int i = 0; i < 66; i++) begin
      prbs_bits[i] = p[30] ^ p[27];
      p = {p[29:0], prbs_bits[i]};
    end
    prbs_d = p;
  end

  // PRBS31 state register; runs whether or not the pattern is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prbs_q <= '1;
    end else begin
      prbs_q <= prbs_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = cfg_tx_prbs31_enable;
`endif

  logic [1:0]  sel_hdr;
  logic [63:0] sel_data;
  logic [1:0]  out_hdr_d, out_hdr_q;
  logic [63:0] out_data_d, out_data_q;

  // Pick scrambled / bypassed / PRBS source, then optionally bit-reverse.
  always_comb begin
    sel_hdr  = enc_hdr_q;
    sel_data = (SCRAMBLER_DISABLE != 0) ? enc_data_q : scr_data;
`ifdef ETH_PHY_10G_TX_PRBS31_EN
    if (cfg_tx_prbs31_enable) begin
      sel_hdr  = ~prbs_bits[1:0];
      sel_data = ~prbs_bits[65:2];
    end
`endif
    out_data_d = '0;
    for (int i = 0; i < 64; i++) begin
      out_data_d[i] = (BIT_REVERSE != 0) ? sel_data[63-i] : sel_data[i];
    end
    out_hdr_d = (BIT_REVERSE != 0) ? {sel_hdr[0], sel_hdr[1]} : sel_hdr;
  end

  // Output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_hdr_q  <= '0;
      out_data_q <= '0;
    end else begin
      out_hdr_q  <= out_hdr_d;
      out_data_q <= out_data_d;
    end
  end

  if (SERDES_PIPELINE == 0) begin : g_no_pipe
    assign bus.serdes_tx_data = out_data_q;
    assign bus.serdes_tx_hdr  = out_hdr_q;
  end else begin : g_pipe
    logic [63:0] pipe_data_q [SERDES_PIPELINE];
    logic [1:0]  pipe_hdr_q  [SERDES_PIPELINE];

    // Extra retiming stages toward the SERDES.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < int'(SERDES_PIPELINE); i++) begin
          pipe_data_q[i] <= '0;
          pipe_hdr_q[i]  <= '0;
        end
      end else begin
        pipe_data_q[0] <= out_data_q;
        pipe_hdr_q[0]  <= out_hdr_q;
        for (int i = 1; i < int'(SERDES_PIPELINE); i++) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
          pipe_hdr_q[i]  <= pipe_hdr_q[i-1];
        end
      end
    end

    assign bus.serdes_tx_data = pipe_data_q[SERDES_PIPELINE-1];
    assign bus.serdes_tx_hdr  = pipe_hdr_q[SERDES_PIPELINE-1];
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_pcs.sv
// Bench for eth_phy_10g_tx_pcs. dut_a: scrambler bypassed, no reversal, no pipeline.
// dut_b: scrambler on, bit-reversed, one extra pipeline stage. Both see the same XGMII.
// PRBS31 section is active when ETH_PHY_10G_TX_PRBS31_EN is defined.
module tb_eth_phy_10g_tx_pcs;

  logic        clk;
  logic        rst;
  logic        cfg;
  logic [63:0] txd;
  logic [7:0]  txc;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [63:0] Err   = {{8{7'h1E}}, 8'h1E};
  localparam logic [63:0] Idle  = 64'h0707070707070707;

  eth_phy_10g_tx_pcs_if bus_a ();
  eth_phy_10g_tx_pcs_if bus_b ();

  assign bus_a.xgmii_txd = txd;
  assign bus_a.xgmii_txc = txc;
  assign bus_b.xgmii_txd = txd;
  assign bus_b.xgmii_txc = txc;

  eth_phy_10g_tx_pcs #(
    .SCRAMBLER_DISABLE (1),
    .BIT_REVERSE       (0),
    .SERDES_PIPELINE   (0)
  ) dut_a (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_tx_prbs31_enable (cfg),
    .bus                  (bus_a)
  );

  eth_phy_10g_tx_pcs #(
    .SCRAMBLER_DISABLE (0),
    .BIT_REVERSE       (1),
    .SERDES_PIPELINE   (1)
  ) dut_b (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_tx_prbs31_enable (cfg),
    .bus                  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state.
  bit          scr_hist[$];
  logic [63:0] prev_data;
  logic [1:0]  prev_hdr;
  logic [63:0] pipe_b_data;
  logic [1:0]  pipe_b_hdr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic string lane_kind(input logic [7:0] b, input logic ctl);
    if (!ctl) return "D";
    case (b)
      8'h07, 8'h06, 8'hFE: return "C";
      8'hFB:               return "S";
      8'hFD:               return "T";
      8'h9C, 8'h5C:        return "O";
      default:             return "X";
    endcase
  endfunction

  function automatic logic [6:0] code_of(input logic [7:0] b);
    case (b)
      8'h06:   return 7'h06;
      8'hFE:   return 7'h1E;
      default: return 7'h00;
    endcase
  endfunction

  // Block format table: lane-kind pattern (lane 0 first), field template, type byte.
  // Template tokens: d=data byte, c=7-bit code, o=O-code, z=4 zero bits, p=pad to fill.
  task automatic block_format(input int f, output string pat, output string tmpl,
                              output logic [7:0] typ);
    logic [7:0] ttab [8];
    ttab = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    pat = ""; tmpl = ""; typ = 8'h00;
    case (f)
      0: begin pat = "CCCCCCCC"; tmpl = "c0c1c2c3c4c5c6c7"; typ = 8'h1E; end
      1: begin pat = "CCCCODDD"; tmpl = "c0c1c2c3o4d5d6d7"; typ = 8'h2D; end
      2: begin pat = "CCCCSDDD"; tmpl = "c0c1c2c3z4d5d6d7"; typ = 8'h33; end
      3: begin pat = "ODDDSDDD"; tmpl = "d1d2d3o0z4d5d6d7"; typ = 8'h66; end
      4: begin pat = "ODDDODDD"; tmpl = "d1d2d3o0o4d5d6d7"; typ = 8'h55; end
      5: begin pat = "SDDDDDDD"; tmpl = "d1d2d3d4d5d6d7";   typ = 8'h78; end
      6: begin pat = "ODDDCCCC"; tmpl = "d1d2d3o0c4c5c6c7"; typ = 8'h4B; end
      default: begin
        for (int i = 0; i < 8; i++) begin
          if (i < f - 7)       pat = {pat, "D"};
          else if (i == f - 7) pat = {pat, "T"};
          else                 pat = {pat, "C"};
        end
        for (int i = 0; i < f - 7; i++) tmpl = {tmpl, $sformatf("d%0d", i)};
        tmpl = {tmpl, "p0"};
        for (int i = f - 6; i < 8; i++) tmpl = {tmpl, $sformatf("c%0d", i)};
        typ = ttab[f - 7];
      end
    endcase
  endtask

  function automatic int field_w(input byte k);
    case (k)
      "d":     return 8;
      "c":     return 7;
      "o":     return 4;
      "z":     return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] pack(input logic [63:0] d, input string tmpl,
                                       input logic [7:0] typ);
    logic [63:0] pl;
    logic [7:0]  v;
    int          pos, lane, w, fixed;
    fixed = 0;
    for (int t = 0; t < tmpl.len() / 2; t++) fixed += field_w(tmpl[2*t]);
    pl = '0;
    pl[7:0] = typ;
    pos = 8;
    for (int t = 0; t < tmpl.len() / 2; t++) begin
      lane = int'(tmpl[2*t+1]) - 48;
      v = 8'h00;
      w = field_w(tmpl[2*t]);
      case (tmpl[2*t])
        "d": v = d[8*lane +: 8];
        "c": v = {1'b0, code_of(d[8*lane +: 8])};
        "o": v = (d[8*lane +: 8] == 8'h5C) ? 8'h0F : 8'h00;
        "p": w = 56 - fixed;
        default: ;
      endcase
      for (int b = 0; b < w; b++) pl[pos + b] = v[b % 8];
      pos += w;
    end
    return pl;
  endfunction

  task automatic model_encode(input logic [63:0] d, input logic [7:0] c,
                              output logic [1:0] hdr, output logic [63:0] pl, output logic bad);
    string      kinds, pat, tmpl;
    logic [7:0] typ;
    bit         hit;
    hdr = 2'b01; pl = Err; bad = 1'b1; hit = 1'b0;
    if (c == 8'h00) begin
      hdr = 2'b10; pl = d; bad = 1'b0;
    end else begin
      kinds = "";
      for (int k = 0; k < 8; k++) kinds = {kinds, lane_kind(d[8*k +: 8], c[k])};
      for (int f = 0; f < 15; f++) begin
        block_format(f, pat, tmpl, typ);
        if (!hit && kinds == pat) begin
          hit = 1'b1;
          pl  = pack(d, tmpl, typ);
          bad = 1'b0;
        end
      end
    end
  endtask

  // Scrambled bit k = d ^ (scrambled bit k-39) ^ (scrambled bit k-58); history seeded with ones.
  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ scr_hist[$-38] ^ scr_hist[$-57];
      scr_hist.push_back(s[i]);
      void'(scr_hist.pop_front());
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  task automatic reset_model();
    scr_hist.delete();
    for (int i = 0; i < 58; i++) scr_hist.push_back(1'b1);
    prev_data   = Err;
    prev_hdr    = 2'b01;
    pipe_b_data = '0;
    pipe_b_hdr  = '0;
  endtask

  // Apply one XGMII word, clock it, and check both DUTs against the model.
  task automatic step(input logic [63:0] d, input logic [7:0] c);
    logic [1:0]  h;
    logic [63:0] p, s;
    logic        b;
    txd = d;
    txc = c;
    model_encode(d, c, h, p, b);
    @(posedge clk);
    #1;
    chk("a_data", bus_a.serdes_tx_data, prev_data);
    chk("a_hdr", bus_a.serdes_tx_hdr, prev_hdr);
    chk("a_bad", bus_a.tx_bad_block, b);
    chk("b_bad", bus_b.tx_bad_block, b);
    chk("b_data", bus_b.serdes_tx_data, pipe_b_data);
    chk("b_hdr", bus_b.serdes_tx_hdr, pipe_b_hdr);
    scramble(prev_data, s);
    pipe_b_data = rev64(s);
    pipe_b_hdr  = {prev_hdr[0], prev_hdr[1]};
    prev_data   = p;
    prev_hdr    = h;
  endtask

  function automatic logic [7:0] pick_ctrl();
    case ($urandom_range(0, 2))
      0:       return 8'h07;
      1:       return 8'h06;
      default: return 8'hFE;
    endcase
  endfunction

  task automatic gen_format(input int f, output logic [63:0] d, output logic [7:0] c);
    string      pat, tmpl;
    logic [7:0] typ;
    block_format(f, pat, tmpl, typ);
    d = {$urandom, $urandom};
    c = 8'h00;
    for (int k = 0; k < 8; k++) begin
      c[k] = (pat[k] != "D");
      case (pat[k])
        "C": d[8*k +: 8] = pick_ctrl();
        "O": d[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'h9C : 8'h5C;
        "S": d[8*k +: 8] = 8'hFB;
        "T": d[8*k +: 8] = 8'hFD;
        default: ;
      endcase
    end
  endtask

  task automatic gen_garbage(output logic [63:0] d, output logic [7:0] c);
    for (int k = 0; k < 8; k++) begin
      c[k] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 8))
        0: d[8*k +: 8] = 8'h07;
        1: d[8*k +: 8] = 8'h06;
        2: d[8*k +: 8] = 8'hFE;
        3: d[8*k +: 8] = 8'hFB;
        4: d[8*k +: 8] = 8'hFD;
        5: d[8*k +: 8] = 8'h9C;
        6: d[8*k +: 8] = 8'h5C;
        7: d[8*k +: 8] = 8'h12;
        default: d[8*k +: 8] = 8'($urandom);
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_data"}, bus_a.serdes_tx_data, 64'h0);
    chk({tag, "_a_hdr"}, bus_a.serdes_tx_hdr, 2'b00);
    chk({tag, "_a_bad"}, bus_a.tx_bad_block, 1'b0);
    chk({tag, "_b_data"}, bus_b.serdes_tx_data, 64'h0);
    chk({tag, "_b_hdr"}, bus_b.serdes_tx_hdr, 2'b00);
    chk({tag, "_b_bad"}, bus_b.tx_bad_block, 1'b0);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  c;
    int          sel;

    rst = 1'b0;
    cfg = 1'b0;
    txd = Idle;
    txc = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b1;
    reset_model();

    // Directed encodings, checked both by the model and by fixed expected words.
    step(Idle, 8'hFF);
    step(64'hD5555555555555FB, 8'h01);
    chk("idle_block", bus_a.serdes_tx_data, 64'h000000000000001E);
    chk("idle_hdr", bus_a.serdes_tx_hdr, 2'b01);
    step(64'h8877665544332211, 8'h00);
    chk("start_block", bus_a.serdes_tx_data, 64'hD555555555555578);
    step(64'h07070707FD332211, 8'hF8);
    chk("data_block", bus_a.serdes_tx_data, 64'h8877665544332211);
    chk("data_hdr", bus_a.serdes_tx_hdr, 2'b10);
    step(Idle, 8'hFF);
    chk("term3_block", bus_a.serdes_tx_data, 64'h00000000332211B4);
    step(64'h0123456789ABCD12, 8'h01);
    chk("bad_pulse", bus_a.tx_bad_block, 1'b1);
    step(Idle, 8'hFF);
    chk("bad_cleared", bus_a.tx_bad_block, 1'b0);
    chk("err_block", bus_a.serdes_tx_data, Err);
    step(64'h07070707070707FD, 8'hFF);
    step(Idle, 8'hFF);
    chk("term0_block", bus_a.serdes_tx_data, 64'h0000000000000087);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 1) begin
        d = {$urandom, $urandom};
        c = 8'h00;
      end else if (sel <= 6) begin
        gen_format($urandom_range(0, 14), d, c);
      end else if (sel == 7) begin
        d = Idle;
        c = 8'hFF;
      end else begin
        gen_garbage(d, c);
      end
`ifndef ETH_PHY_10G_TX_PRBS31_EN
      cfg = 1'($urandom_range(0, 1));
`endif
      step(d, c);
    end

    // Asynchronous reset mid-stream, then all-zero data to expose the scrambler sequence.
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst1");
    cfg = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    for (int n = 0; n < 24; n++) step(64'h0, 8'h00);

`ifdef ETH_PHY_10G_TX_PRBS31_EN
    begin
      bit          pq[$];
      logic [65:0] blk;
      bit          nb;
      rst = 1'b0;
      cfg = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 31; i++) pq.push_back(1'b1);
      // b[k] = b[k-31] ^ b[k-28], seeded with 31 ones.
      for (int cyc = 0; cyc < 1000; cyc++) begin
        for (int j = 0; j < 66; j++) begin
          nb = pq[0] ^ pq[3];
          pq.push_back(nb);
          void'(pq.pop_front());
          blk[j] = nb;
        end
        @(posedge clk);
        #1;
        chk("prbs_hdr", bus_a.serdes_tx_hdr, ~blk[1:0]);
        chk("prbs_data", bus_a.serdes_tx_data, ~blk[65:2]);
      end
      cfg = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_tx_pcs.md
# eth_phy_10g_tx_pcs

10GBASE-R transmit PCS datapath between the MAC's 64-bit XGMII TX bus and the SERDES gearbox. Encodes each XGMII cycle into a 64b/66b block per IEEE 802.3 Clause 49, scrambles the payload with x^58+x^39+1, and optionally replaces the output with a PRBS31 test pattern. Drives `serdes_tx_data`/`serdes_tx_hdr` directly.

## Interface
- `DATA_WIDTH`, 64, XGMII/SERDES data width; any other value is a fatal elaboration error.
- `CTRL_WIDTH`, DATA_WIDTH/8, XGMII control lanes; must equal DATA_WIDTH/8.
- `HDR_WIDTH`, 2, sync header width; must be 2.
- `BIT_REVERSE`, 0, 1 = bit-reverse data and header at the output.
- `SCRAMBLER_DISABLE`, 0, 1 = bypass the scrambler.
- `SERDES_PIPELINE`, 0, extra output register stages (0..n).

- `clk` in 1: single clock; all logic in this domain.
- `rst` in 1: **asynchronous, active-low** reset.
- `xgmii_txd` in 64: XGMII data, lane k = bits 8k+7:8k.
- `xgmii_txc` in 8: XGMII control, bit k for lane k.
- `serdes_tx_data` out 64: block payload, bit 0 transmitted first.
- `serdes_tx_hdr` out 2: sync header, bit 0 transmitted first.
- `tx_bad_block` out 1: pulse when the input was not encodable.
- `cfg_tx_prbs31_enable` in 1: select PRBS31 output (requires the macro).

## Operation
- **Sync header:**
  - All txc=0: hdr=2'b10, payload=txd.
  - Otherwise: hdr=2'b01.
- **Control code map** (XGMII to 7-bit): 0x07 idle→0x00, 0x06 LPI→0x06, 0xFE error→0x1E. Any other control byte is invalid.
- **O-codes:** 0x9C→0x0, 0x5C→0xF. O-code lanes carry D1..D3 in lanes 1..3 (or 5..7).
- **Control block layout:** type byte in bits 7:0.
  - Data bytes are 8 bits each; control codes are 7 bits each; O-codes are 4 bits each.
  - Fields are packed upward from bit 8 in lane order.
- **Block types:**
  - 0x1E: C0..C7.
  - 0x2D: C0..C3, O4, D5..D7.
  - 0x33: C0..C3, 4'b0, D5..D7 (Start in lane 4).
  - 0x66: D1..D3, O0, 4'b0, D5..D7.
  - 0x55: D1..D3, O0, O4, D5..D7.
  - 0x78: D1..D7 (Start 0xFB in lane 0).
  - 0x4B: D1..D3, O0, C4..C7.
- **Terminate in lane n** (0xFD): types 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF for n=0..7.
  - Layout: D0..D(n-1), zero pad, then C(n+1)..C7 MSB-aligned.
  - Lanes after T must hold valid control codes.
- **Invalid input** (any other txc/txd combination):
  - Emit hdr=01, payload {8{7'h1E}} with type 0x1E.
  - Assert `tx_bad_block` for that block.
- **Scrambler:** for each payload bit i (LSB first), out = d ^ s[38] ^ s[57]. Out is shifted into the 58-bit state. The header is never scrambled.
- **Output order:** BIT_REVERSE is applied after scrambling/PRBS.

## Timing
- Encoder register: 1 cycle. Scrambler/PRBS output register: 1 cycle.
- Total input→serdes latency = 2 + SERDES_PIPELINE cycles. `tx_bad_block` latency = 1 cycle.
- **Reset values** (rst=0, asynchronous):
  - Encoder output = error block (hdr 01, type 0x1E, all 0x1E).
  - `tx_bad_block`=0.
  - Scrambler state = all ones; PRBS state = all ones.
  - `serdes_tx_data`=0, `serdes_tx_hdr`=0, including pipeline stages.
- Reset release mid-frame: encoding resumes on the first clock after release. No state carries across reset.
- Back-to-back blocks are accepted every cycle. No handshake; input is sampled every clock.

## Configuration
- Macro `ETH_PHY_10G_TX_PRBS31_EN`.
- **Defined:**
  - A 31-bit LFSR, x^31+x^28+1, reset all ones, advances 66 bits per cycle.
  - While `cfg_tx_prbs31_enable`=1: hdr = inverted PRBS bits 0..1, data = inverted bits 2..65.
  - The scrambler keeps running meanwhile.
- **Undefined:** no LFSR; `cfg_tx_prbs31_enable` is ignored.

## Test plan
- Reset held low, then idle XGMII (txd=0x0707070707070707, txc=0xFF) → before scrambling: hdr=01, payload=0x000000000000001E; tx_bad_block=0.
- Start (txd=0xD5555555555555FB, txc=0x01) then data (txc=0x00) → hdr 01 type 0x78 with D1..D7 = 55..D5, then hdr 10 with payload = txd. Check with SCRAMBLER_DISABLE=1.
- Terminate in lane 3 (txd=0x07070707FDxxxxxx, txc=0xF8) → type 0xB4, D0..D2 preserved, C4..C7=0x00.
- Invalid control byte 0x12 with txc=0x01 → error block type 0x1E with all codes 0x1E; tx_bad_block=1 for exactly one cycle.
- Scrambler enabled, all-zero data blocks after reset → payload matches a reference x^58+x^39+1 model seeded with all ones; hdr=10 unscrambled.
- Macro defined, cfg_tx_prbs31_enable=1 → 66-bit stream matches inverted PRBS31 with zero errors over 1000 cycles.
